// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : 16-bit PC fetch stage with IF/ID register and BUBBLE/RUN/FAULT
//               control. The optional fetch bounds check is enabled by the
//               macro FETCH_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_LIMIT = 16'h001C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    input  logic [15:0] instruction,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_BUBBLE = 2'd0,
        S_RUN    = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    // The PC is held as a halfword index so it can never be odd.
    localparam logic [14:0] c_RESET_WORD = RESET_PC[15:1];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [14:0] r_pc_word;
    logic [14:0] w_pc_word_nxt;
    logic [15:0] r_instr;
    logic [15:0] w_instr_nxt;
    logic [15:0] r_pc2;
    logic [15:0] w_pc2_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [15:0] w_pc_plus2;
    logic        w_unused;

    assign w_pc_plus2 = {r_pc_word + 15'd1, 1'b0};
    assign w_unused   = redirect_pc[0];

`ifdef FETCH_BOUNDS_CHECK_EN
    logic r_fault;
    logic w_fault_nxt;
    logic w_out_of_range;

    assign w_out_of_range = ({r_pc_word, 1'b0} > PC_LIMIT);
    assign fetch_fault    = r_fault;
`else
    assign fetch_fault    = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_word_nxt = r_pc_word;
        w_instr_nxt   = r_instr;
        w_pc2_nxt     = r_pc2;
        w_valid_nxt   = r_valid;
`ifdef FETCH_BOUNDS_CHECK_EN
        w_fault_nxt   = r_fault;
`endif
        case (r_state)
            S_BUBBLE: begin
                w_valid_nxt = 1'b0;
                if (redirect) begin
                    w_pc_word_nxt = redirect_pc[15:1];
                end else if (!stall) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
`ifdef FETCH_BOUNDS_CHECK_EN
                if (w_out_of_range) begin
                    w_state_nxt = S_FAULT;
                    w_fault_nxt = 1'b1;
                    w_valid_nxt = 1'b0;
                end else
`endif
                if (redirect) begin
                    // Flush: only the valid bit drops, payload fields hold.
                    w_pc_word_nxt = redirect_pc[15:1];
                    w_valid_nxt   = 1'b0;
                end else if (!stall) begin
                    w_pc_word_nxt = r_pc_word + 15'd1;
                    w_instr_nxt   = instruction;
                    w_pc2_nxt     = w_pc_plus2;
                    w_valid_nxt   = 1'b1;
                end
            end
            S_FAULT: begin
`ifdef FETCH_BOUNDS_CHECK_EN
                w_valid_nxt = 1'b0;
`else
                w_state_nxt = S_BUBBLE;
`endif
            end
            default: begin
                w_state_nxt = S_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_BUBBLE;
            r_pc_word <= c_RESET_WORD;
            r_instr   <= 16'h0000;
            r_pc2     <= 16'h0000;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc_word <= w_pc_word_nxt;
            r_instr   <= w_instr_nxt;
            r_pc2     <= w_pc2_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
        end
    end
`endif

    assign pc          = {r_pc_word, 1'b0};
    assign if_id_instr = r_instr;
    assign if_id_pc2   = r_pc2;
    assign if_id_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [15:0] c_A = 16'hA0A1;
    localparam logic [15:0] c_B = 16'hB0B2;
    localparam logic [15:0] c_C = 16'hC0C3;
    localparam logic [15:0] c_D = 16'hD0D4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        fetch_fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Words 0..3 are A..D; everything else is a recognisable pattern of pc.
    function automatic logic [15:0] imem(input logic [15:0] a);
        case (a)
            16'h0000: imem = c_A;
            16'h0002: imem = c_B;
            16'h0004: imem = c_C;
            16'h0006: imem = c_D;
            default:  imem = a ^ 16'h5A5A;
        endcase
    endfunction

    assign instruction = imem(pc);

    instruction_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .instruction (instruction),
        .if_id_instr (if_id_instr),
        .if_id_pc2   (if_id_pc2),
        .if_id_valid (if_id_valid),
        .fetch_fault (fetch_fault)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [15:0] e_pc, input logic e_valid,
                          input logic [15:0] e_instr, input logic [15:0] e_pc2);
        chk({tag, ".pc"},    pc,                  e_pc);
        chk({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, e_valid});
        chk({tag, ".instr"}, if_id_instr,         e_instr);
        chk({tag, ".pc2"},   if_id_pc2,           e_pc2);
        chk({tag, ".fault"}, {15'd0, fetch_fault}, 16'h0000);
    endtask

    initial begin
        logic [15:0] e_pc;

        // Reset state
        step();
        step();
        chk_if("rst", 16'h0000, 1'b0, 16'h0000, 16'h0000);

        // Reset release: BUBBLE, then A, B, C
        reset = 1'b0;
        step(); chk_if("rel0", 16'h0000, 1'b0, 16'h0000, 16'h0000);
        step(); chk_if("rel1", 16'h0002, 1'b1, c_A, 16'h0002);
        step(); chk_if("rel2", 16'h0004, 1'b1, c_B, 16'h0004);
        step(); chk_if("rel3", 16'h0006, 1'b1, c_C, 16'h0006);

        // Stall for three cycles at pc 6
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_if("stall", 16'h0006, 1'b1, c_C, 16'h0006);
        end
        stall = 1'b0;
        step(); chk_if("unstall", 16'h0008, 1'b1, c_D, 16'h0008);

        // Redirect beats stall, odd target forced even
        redirect = 1'b1; redirect_pc = 16'h0013; stall = 1'b1;
        step(); chk_if("redir", 16'h0012, 1'b0, c_D, 16'h0008);
        redirect = 1'b0; stall = 1'b0;
        step(); chk_if("redir1", 16'h0014, 1'b1, imem(16'h0012), 16'h0014);

        // Back-to-back redirects
        redirect = 1'b1; redirect_pc = 16'h0040;
        step(); chk_if("b2b0", 16'h0040, 1'b0, imem(16'h0012), 16'h0014);
        redirect_pc = 16'h0060;
        step(); chk_if("b2b1", 16'h0060, 1'b0, imem(16'h0012), 16'h0014);
        redirect = 1'b0;
        step(); chk_if("b2b2", 16'h0062, 1'b1, imem(16'h0060), 16'h0062);

        // Wrap at top of address space
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step(); chk_if("wrap0", 16'hFFFE, 1'b0, imem(16'h0060), 16'h0062);
        redirect = 1'b0;
        step(); chk_if("wrap1", 16'h0000, 1'b1, imem(16'hFFFE), 16'h0000);

        // Run to pc 0xA, then reset during a redirect
        for (int i = 1; i <= 5; i++) begin
            e_pc = 16'(2 * i);
            step(); chk_if("run", e_pc, 1'b1, imem(e_pc - 16'd2), e_pc);
        end
        redirect = 1'b1; redirect_pc = 16'h0030; reset = 1'b1;
        step(); chk_if("rstredir", 16'h0000, 1'b0, 16'h0000, 16'h0000);
        redirect = 1'b0; reset = 1'b0;
        step(); chk_if("rebub", 16'h0000, 1'b0, 16'h0000, 16'h0000);
        step(); chk_if("rerun", 16'h0002, 1'b1, c_A, 16'h0002);

        // Sequential run up to 0x1E
        for (int i = 2; i <= 15; i++) begin
            e_pc = 16'(2 * i);
            step(); chk("seq.pc", pc, e_pc);
        end
        chk("seq.pc1e", pc, 16'h001E);
        step();
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("bnd.pc",    pc, 16'h001E);
        chk("bnd.fault", {15'd0, fetch_fault}, 16'h0001);
        chk("bnd.valid", {15'd0, if_id_valid}, 16'h0000);
        redirect = 1'b1; redirect_pc = 16'h0050;
        step();
        chk("bnd.frz",   pc, 16'h001E);
        chk("bnd.stick", {15'd0, fetch_fault}, 16'h0001);
`else
        chk("bnd.pc",    pc, 16'h0020);
        chk("bnd.fault", {15'd0, fetch_fault}, 16'h0000);
        chk("bnd.valid", {15'd0, if_id_valid}, 16'h0001);
        chk("bnd.instr", if_id_instr, imem(16'h001E));
        redirect = 1'b1; redirect_pc = 16'h0050;
        step();
        chk("bnd.redir", pc, 16'h0050);
        chk("bnd.f0",    {15'd0, fetch_fault}, 16'h0000);
`endif
        redirect = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk_if("fltrst", 16'h0000, 1'b0, 16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter PC_LIMIT, default 16'h001C, last legal fetch address; used only under REQ-030.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID register (hazard unit).
REQ-006 redirect  input  1  taken branch/jump; load redirect_pc, flush IF/ID.
REQ-007 redirect_pc  input  16  target byte address.
REQ-008 pc  output  16  fetch address driven to instruction memory.
REQ-009 instruction  input  16  instruction word returned combinationally for current pc.
REQ-010 if_id_instr  output  16  registered instruction to decode.
REQ-011 if_id_pc2  output  16  registered pc+2 of that instruction.
REQ-012 if_id_valid  output  1  if_id_instr is a real instruction, not a bubble.
REQ-013 fetch_fault  output  1  sticky out-of-range fetch flag.

Function
REQ-014 The block SHALL hold a 16-bit PC register driven directly onto pc, always even (bit 0 forced 0).
REQ-015 The block SHALL implement FSM states BUBBLE, RUN, FAULT; reset enters BUBBLE.
REQ-016 BUBBLE: if_id_valid=0 for exactly one cycle, PC not advanced; next state RUN unless a redirect is asserted, which loads PC and stays BUBBLE.
REQ-017 RUN, no stall/redirect: next PC = PC+2; IF/ID captures instruction, PC+2, valid=1; fetch latency one cycle from pc to if_id_instr.
REQ-018 Priority SHALL be reset > redirect > stall > sequential advance.
REQ-019 redirect: next PC = {redirect_pc[15:1],1'b0}; IF/ID captures valid=0 (flush) in the same edge; instr/pc2 fields hold previous values.
REQ-020 stall without redirect: PC, if_id_instr, if_id_pc2, if_id_valid all hold unchanged.
REQ-021 redirect and stall together: redirect wins; stall ignored that cycle.
REQ-022 PC increment SHALL wrap modulo 2^16: 16'hFFFE advances to 16'h0000, if_id_pc2 = 16'h0000.
REQ-023 Back-to-back redirects SHALL each load their target; if_id_valid stays 0 until the first sequential advance.
REQ-024 if_id_pc2 SHALL be the 16-bit sum PC+2, carry discarded.
REQ-025 FAULT state exists only under REQ-030; otherwise the FSM never leaves BUBBLE/RUN and fetch_fault=0.

Reset
REQ-026 On reset: pc=RESET_PC, if_id_instr=16'h0000, if_id_pc2=16'h0000, if_id_valid=0, fetch_fault=0, state=BUBBLE.
REQ-027 Reset asserted mid-stall, mid-redirect or in FAULT SHALL override everything and take effect on the next edge.
REQ-028 First valid instruction SHALL appear on if_id_instr two edges after reset deasserts (BUBBLE then RUN capture).
REQ-029 Outputs SHALL be register-driven only; no combinational path from inputs to if_id_* or fetch_fault.

Configuration
REQ-030 Macro FETCH_BOUNDS_CHECK_EN: when defined, a fetch in RUN with pc > PC_LIMIT enters FAULT: fetch_fault=1 (sticky), if_id_valid=0, PC frozen, stall/redirect ignored, exit only by reset; when undefined, no comparator, fetch_fault tied 0, PC runs freely and wraps per REQ-022.

Verification
REQ-031 Reset release, instruction memory words 0..3 = A,B,C,D -> pc 0,0,2,4,6; if_id_valid 0,0,1,1; if_id_instr A,B,C; if_id_pc2 2,4,6.
REQ-032 stall high 3 cycles at pc=16'h0006 -> pc stays 6, if_id_* unchanged 3 cycles, then resumes 8.
REQ-033 redirect=1, redirect_pc=16'h0013 with stall=1 at pc=16'h0008 -> next pc 16'h0012, if_id_valid=0 one cycle, then instruction at 0x12 valid.
REQ-034 redirect_pc=16'hFFFE, run 2 cycles -> pc 16'hFFFE then 16'h0000, if_id_pc2=16'h0000.
REQ-035 FETCH_BOUNDS_CHECK_EN defined, sequential run from 0 -> at pc=16'h001E fetch_fault=1, if_id_valid=0, pc frozen despite redirect; reset clears; undefined build -> pc continues 16'h0020, fault 0.
REQ-036 reset pulsed during redirect at pc=16'h000A -> pc=RESET_PC, all if_id_* cleared, BUBBLE cycle repeated.
